crp_collector: RTL and testbench
================================

# crp_collector

Challenge-side controller for the multi-PUF arrays. It drives a challenge word and excite/clear strobes to N_PUF parallel arbiter-PUF slices and waits a programmable settle time. It then samples their response bits through a synchroniser and packs the bits of several consecutive challenges into one response word. The word is handed to downstream logic over a valid/ready handshake. It sits between the PUF slice array and the readout/UART path.

## Interface
- CHAL_W, 3, challenge width driven to every slice
- N_PUF, 4, number of slices sampled in parallel (response bits per challenge)
- RESP_W, 32, output word width; must be a multiple of N_PUF (M = RESP_W/N_PUF challenges per word)
- SETTLE, 8, cycles waited after excite before sampling; must be ≥ 2

- clk  in  1  single clock
- clr  in  1  reset, synchronous, active-high
- start  in  1  request one response word; honoured only in IDLE
- seed  in  CHAL_W  first challenge of the word, captured when start is accepted
- busy  out  1  high in every state except IDLE
- chal  out  CHAL_W  challenge to all slices
- puf_clr  out  1  clear strobe to slice flip-flops
- puf_en  out  1  excite strobe (slice clock/launch input)
- resp_in  in  N_PUF  raw slice responses, asynchronous to clk
- resp_data  out  RESP_W  packed response word
- resp_valid  out  1  resp_data valid
- resp_ready  in  1  downstream accepts

## Operation
- FSM states: IDLE, CLEAR, EXCITE, SETTLE, SAMPLE, OUTPUT.
- IDLE:
  - start=1 → CLEAR.
  - On the same edge: chal←seed, challenge counter k←0, shift register←0.
- CLEAR: puf_clr=1 for exactly one cycle → EXCITE.
- EXCITE: puf_en=1 for exactly one cycle → SETTLE. Settle counter loads SETTLE-1.
- SETTLE: counter decrements each cycle. At 0 → SAMPLE. Occupies exactly SETTLE cycles.
- SAMPLE:
  - shreg ← {shreg[RESP_W-N_PUF-1:0], resp_sync}, so the first challenge ends in the MSBs.
  - chal ← chal+1, modulo 2^CHAL_W (wrap silently).
  - k ← k+1.
  - If k was M-1 → OUTPUT, otherwise → CLEAR.
- OUTPUT: resp_valid=1, resp_data=shreg, held stable until resp_ready=1. The handshake edge → IDLE.
- resp_in passes through a 2-flop synchroniser on every bit. The SETTLE ≥ 2 requirement covers this latency.
- chal stays constant from CLEAR through SAMPLE of each challenge. It changes only on the SAMPLE edge or at start acceptance.
- puf_clr and puf_en are registered outputs and are never high simultaneously.
- start outside IDLE is ignored. This includes start in the cycle of the OUTPUT handshake.
- Out-of-range parameters (RESP_W mod N_PUF ≠ 0, SETTLE < 2) are an elaboration error.

## Timing
- Reset (clr=1 at an edge):
  - state=IDLE.
  - busy, puf_clr, puf_en, resp_valid = 0.
  - chal, resp_data, and all counters = 0.
  - Synchroniser flops = 0.
- Reset mid-operation abandons the word. The partial data is discarded and no resp_valid is produced.
- Each challenge takes SETTLE+3 cycles: CLEAR, EXCITE, SETTLE×SETTLE, SAMPLE.
- Latency: for start accepted at edge 0, resp_valid is first high in cycle 1 + M·(SETTLE+3).
- Handshake:
  - A transfer occurs on an edge where resp_valid=1 and resp_ready=1.
  - resp_valid is low from the following cycle.
  - resp_ready high before resp_valid completes the transfer on the first valid cycle.
  - resp_ready low stalls indefinitely with no data change.
- Earliest next start: the cycle after the handshake (state IDLE). busy falls in that same cycle.

## Structure
- Package crp_pkg:
  - state enum typedef (IDLE..OUTPUT)
  - localparam helper for M
  - settle-counter width function ($clog2(SETTLE))
- Sub-module resp_sync: N_PUF-wide 2-flop synchroniser with synchronous clr. It is instantiated once and marked dont_touch, consistent with the slice primitives.
- All other logic (FSM, counters, shift register) stays in crp_collector.

## Test plan
Scenarios 1–5 use N_PUF=4, RESP_W=8, SETTLE=4, CHAL_W=3, giving M=2 and 7 cycles per challenge.
1. Basic word:
   - Stimulus: seed=3, resp_in=4'hA for the first challenge, then 4'h5 for the second; resp_ready=1.
   - Required: chal=3 then 4; resp_valid high at cycle 15 after the start edge; resp_data=8'hA5; busy low at cycle 16.
2. Wrap:
   - Stimulus: seed=7.
   - Required: chal sequence 7, 0; no glitch on the other chal bits during CLEAR–SAMPLE.
3. Backpressure:
   - Stimulus: resp_ready held low 10 cycles after resp_valid rises.
   - Required: resp_data=8'hA5 stable and resp_valid high for all 10 cycles; transfer on the first ready edge.
4. Reset mid-word:
   - Stimulus: clr=1 during the second challenge's SETTLE.
   - Required: next cycle all outputs 0; state IDLE; no resp_valid afterwards; a following start yields a fresh correct word.
5. Ignored start:
   - Stimulus: start pulsed in SETTLE and again in the handshake cycle.
   - Required: no restart, no chal reload; IDLE is reached after the handshake and a start one cycle later is accepted.
6. Strobes and synchroniser:
   - Stimulus: resp_in toggling every cycle with default parameters.
   - Required: puf_clr and puf_en are single-cycle and mutually exclusive; the sampled value equals resp_in from 2 cycles before the SAMPLE edge.

Source files
------------

// File: rtl/crp_pkg.sv
// Shared types and sizing helpers for the challenge/response collector.
package crp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_EXCITE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_OUTPUT
  } crp_state_t;

  function automatic int words_per_resp(input int resp_w, input int n_puf);
    return resp_w / n_puf;
  endfunction

  function automatic int settle_cnt_w(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

  function automatic int chal_cnt_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/resp_sync.sv
// Two-flop synchroniser for the asynchronous PUF slice responses.
module resp_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [N-1:0] meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/crp_collector.sv
// Drives challenges and strobes to the PUF slices, samples their responses
// after a settle time and packs M challenges into one handshaked word.
module crp_collector
  import crp_pkg::*;
#(
  parameter int CHAL_W = 3,
  parameter int N_PUF  = 4,
  parameter int RESP_W = 32,
  parameter int SETTLE = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  output logic              busy,
  output logic [CHAL_W-1:0] chal,
  output logic              puf_clr,
  output logic              puf_en,
  input  logic [N_PUF-1:0]  resp_in,
  output logic [RESP_W-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam int M     = words_per_resp(RESP_W, N_PUF);
  localparam int CNT_W = settle_cnt_w(SETTLE);
  localparam int K_W   = chal_cnt_w(M);

  if ((RESP_W % N_PUF) != 0 || SETTLE < 2) begin : g_bad_params
    $error("crp_collector: RESP_W must be a multiple of N_PUF and SETTLE must be >= 2");
  end

  crp_state_t        state, next_state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [K_W-1:0]    k;
  logic [RESP_W-1:0] shreg;
  logic [N_PUF-1:0]  resp_synced;
  logic              busy_d, clr_d, en_d, valid_d;

  (* dont_touch = "true" *)
  resp_sync #(.N(N_PUF)) u_resp_sync (
    .clk (clk),
    .clr (clr),
    .d   (resp_in),
    .q   (resp_synced)
  );

  // Strobes and status are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      puf_clr    <= 1'b0;
      puf_en     <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= busy_d;
      puf_clr    <= clr_d;
      puf_en     <= en_d;
      resp_valid <= valid_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_CLEAR;
      ST_CLEAR:  next_state = ST_EXCITE;
      ST_EXCITE: next_state = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == '0) next_state = ST_SAMPLE;
      ST_SAMPLE: next_state = (k == K_W'(M - 1)) ? ST_OUTPUT : ST_CLEAR;
      ST_OUTPUT: if (resp_ready) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (next_state != ST_IDLE);
    clr_d   = (next_state == ST_CLEAR);
    en_d    = (next_state == ST_EXCITE);
    valid_d = (next_state == ST_OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      chal       <= '0;
      settle_cnt <= '0;
      k          <= '0;
      shreg      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            chal  <= seed;
            k     <= '0;
            shreg <= '0;
          end
        end
        ST_EXCITE: settle_cnt <= CNT_W'(SETTLE - 1);
        ST_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        // Earlier challenges shift toward the MSBs; the counter wraps silently.
        ST_SAMPLE: begin
          shreg <= (shreg << N_PUF) | RESP_W'(resp_synced);
          chal  <= chal + 1'b1;
          k     <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_data = shreg;

endmodule

// File: tb/tb_crp_collector.sv
// Directed bench: a small-config instance for the word/handshake scenarios
// and a default-config instance for strobe and synchroniser timing.
module tb_crp_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, start, resp_ready;
  logic [2:0] seed;
  logic [3:0] resp_in;
  logic       busy, puf_clr, puf_en, resp_valid;
  logic [2:0] chal;
  logic [7:0] resp_data;

  logic        d_start, d_resp_ready;
  logic [2:0]  d_seed;
  logic [3:0]  d_resp_in;
  logic        d_busy, d_puf_clr, d_puf_en, d_resp_valid;
  logic [2:0]  d_chal;
  logic [31:0] d_resp_data;

  int vectors = 0;
  int miscompares = 0;

  crp_collector #(.CHAL_W(3), .N_PUF(4), .RESP_W(8), .SETTLE(4)) u_dut (
    .clk(clk), .clr(clr), .start(start), .seed(seed), .busy(busy), .chal(chal),
    .puf_clr(puf_clr), .puf_en(puf_en), .resp_in(resp_in), .resp_data(resp_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  crp_collector u_dut_def (
    .clk(clk), .clr(clr), .start(d_start), .seed(d_seed), .busy(d_busy), .chal(d_chal),
    .puf_clr(d_puf_clr), .puf_en(d_puf_en), .resp_in(d_resp_in), .resp_data(d_resp_data),
    .resp_valid(d_resp_valid), .resp_ready(d_resp_ready)
  );

  // Cycle n is the period ending at edge n; stepping lands 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input logic [2:0] s);
    start = 1'b1;
    seed  = s;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    vectors++;
    if ({busy, puf_clr, puf_en, resp_valid} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b expected 0000", {busy, puf_clr, puf_en, resp_valid});
    end
    vectors++;
    if ({chal, resp_data} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got chal=%0h data=%0h expected 0/0", chal, resp_data);
    end
    vectors++;
    if ({d_busy, d_puf_clr, d_puf_en, d_resp_valid, d_chal} !== 7'd0 || d_resp_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_default got busy=%b chal=%0h data=%0h expected all 0", d_busy, d_chal, d_resp_data);
    end
  endtask

  task automatic test_basic();
    resp_ready = 1'b1;
    resp_in    = 4'hA;
    start_word(3'd3);
    for (int c = 1; c <= 15; c++) begin
      logic [2:0] ec;
      logic [1:0] es;
      if (c == 8) resp_in = 4'h5;
      ec = (c <= 7) ? 3'd3 : (c <= 14) ? 3'd4 : 3'd5;
      es = (c == 1 || c == 8) ? 2'b10 : (c == 2 || c == 9) ? 2'b01 : 2'b00;
      vectors++;
      if (chal !== ec) begin
        miscompares++;
        $display("[TB] FAIL basic_chal cycle %0d got %0d expected %0d", c, chal, ec);
      end
      vectors++;
      if (resp_valid !== (c == 15)) begin
        miscompares++;
        $display("[TB] FAIL basic_valid cycle %0d got %b expected %b", c, resp_valid, (c == 15));
      end
      vectors++;
      if ({puf_clr, puf_en} !== es) begin
        miscompares++;
        $display("[TB] FAIL basic_strobes cycle %0d got %b expected %b", c, {puf_clr, puf_en}, es);
      end
      if (c < 15) tick();
    end
    vectors++;
    if (resp_data !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL basic_data got %0h expected a5", resp_data);
    end
    tick();
    vectors++;
    if ({busy, resp_valid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL basic_idle got busy=%b valid=%b expected 0/0", busy, resp_valid);
    end
  endtask

  task automatic test_wrap();
    resp_ready = 1'b1;
    resp_in    = 4'h3;
    start_word(3'd7);
    for (int c = 1; c <= 14; c++) begin
      logic [2:0] ec;
      ec = (c <= 7) ? 3'd7 : 3'd0;
      vectors++;
      if (chal !== ec) begin
        miscompares++;
        $display("[TB] FAIL wrap_chal cycle %0d got %0d expected %0d", c, chal, ec);
      end
      tick();
    end
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 8'h33) begin
      miscompares++;
      $display("[TB] FAIL wrap_word got valid=%b data=%0h expected 1/33", resp_valid, resp_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    resp_in    = 4'hA;
    start_word(3'd3);
    for (int c = 1; c <= 14; c++) begin
      if (c == 8) resp_in = 4'h5;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_data !== 8'hA5) begin
        miscompares++;
        $display("[TB] FAIL stall_hold wait %0d got valid=%b data=%0h expected 1/a5", i, resp_valid, resp_data);
      end
      tick();
    end
    resp_ready = 1'b1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL stall_release got valid=%b data=%0h expected 1/a5", resp_valid, resp_data);
    end
    tick();
    vectors++;
    if ({busy, resp_valid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL stall_transfer got busy=%b valid=%b expected 0/0", busy, resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    resp_ready = 1'b1;
    resp_in    = 4'hA;
    start_word(3'd2);
    for (int c = 1; c <= 9; c++) begin
      if (c == 8) resp_in = 4'h5;
      tick();
    end
    vectors++;
    if (busy !== 1'b1 || chal !== 3'd3) begin
      miscompares++;
      $display("[TB] FAIL midreset_pre got busy=%b chal=%0d expected 1/3", busy, chal);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if ({busy, puf_clr, puf_en, resp_valid} !== 4'b0000 || chal !== 3'd0 || resp_data !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_clear got flags=%b chal=%0d data=%0h expected 0", {busy, puf_clr, puf_en, resp_valid}, chal, resp_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_quiet got activity=%b expected 0", seen);
    end
    resp_in = 4'hA;
    start_word(3'd5);
    for (int c = 1; c <= 14; c++) begin
      if (c == 8) resp_in = 4'h5;
      tick();
    end
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 8'hA5 || chal !== 3'd7) begin
      miscompares++;
      $display("[TB] FAIL midreset_fresh got valid=%b data=%0h chal=%0d expected 1/a5/7", resp_valid, resp_data, chal);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    resp_ready = 1'b0;
    resp_in    = 4'hA;
    start_word(3'd4);
    tick();
    tick();
    tick();
    start = 1'b1;
    seed  = 3'd0;
    tick();
    start = 1'b0;
    vectors++;
    if (chal !== 3'd4 || puf_clr !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ignore_settle got chal=%0d clr=%b busy=%b expected 4/0/1", chal, puf_clr, busy);
    end
    for (int c = 5; c <= 14; c++) begin
      if (c == 8) resp_in = 4'h5;
      tick();
    end
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL ignore_word got valid=%b data=%0h expected 1/a5", resp_valid, resp_data);
    end
    resp_ready = 1'b1;
    start      = 1'b1;
    seed       = 3'd1;
    tick();
    start      = 1'b0;
    resp_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || chal !== 3'd6) begin
      miscompares++;
      $display("[TB] FAIL ignore_handshake got busy=%b valid=%b chal=%0d expected 0/0/6", busy, resp_valid, chal);
    end
    start_word(3'd2);
    vectors++;
    if (busy !== 1'b1 || chal !== 3'd2 || puf_clr !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ignore_restart got busy=%b chal=%0d clr=%b expected 1/2/1", busy, chal, puf_clr);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_strobes();
    logic [3:0]  hist [0:89];
    logic [31:0] exp_word;
    d_resp_ready = 1'b1;
    d_start      = 1'b1;
    d_seed       = 3'd0;
    tick();
    d_start = 1'b0;
    for (int c = 1; c <= 89; c++) begin
      logic ec, ee;
      hist[c]   = 4'((c * 7) + 3);
      d_resp_in = hist[c];
      ec = (c <= 88) && ((c % 11) == 1);
      ee = (c <= 88) && ((c % 11) == 2);
      vectors++;
      if ({d_puf_clr, d_puf_en} !== {ec, ee}) begin
        miscompares++;
        $display("[TB] FAIL strobe_timing cycle %0d got %b expected %b", c, {d_puf_clr, d_puf_en}, {ec, ee});
      end
      if (c < 89) tick();
    end
    exp_word = '0;
    for (int j = 0; j < 8; j++) exp_word = {exp_word[27:0], hist[(11 * j) + 9]};
    vectors++;
    if (d_resp_valid !== 1'b1 || d_resp_data !== exp_word) begin
      miscompares++;
      $display("[TB] FAIL sync_word got valid=%b data=%08h expected 1/%08h", d_resp_valid, d_resp_data, exp_word);
    end
    tick();
    vectors++;
    if (d_busy !== 1'b0 || d_chal !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL default_done got busy=%b chal=%0d expected 0/0", d_busy, d_chal);
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; seed = '0; resp_in = '0; resp_ready = 1'b0;
    d_start = 1'b0; d_seed = '0; d_resp_in = '0; d_resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_ignored_start();
    test_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
